solver_dispatcher: RTL and testbench

//  Shares NUM_SOLVERS Mandelbrot solver_control/datapath instances between one pixel-job stream.
//  - Accepts tagged jobs as limb-serial c (re/im) streams.
//  - Loads each job into a free solver, configures it, and starts it.
//  - Collects iteration counts round-robin onto one tagged result stream.
//  - Sits between the host/tile interface and the solver array.

---
 rtl/solver_dispatcher.sv | 166 ++++++++++++++++
 tb/tb_solver_dispatcher.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/solver_dispatcher.sv
// rtl/solver_dispatcher.sv - shares a pool of Mandelbrot solvers between one tagged job stream
// Dispatches limb-serial jobs to free solvers and collects results round-robin.
module solver_dispatcher #(
  parameter int NUM_SOLVERS     = 4,
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32,
  parameter int TAG_BITS        = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cfg_wr,
  input  logic [LIMB_INDEX_BITS-1:0]  cfg_num_limbs,
  input  logic [15:0]                 cfg_iter_lim,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LIMB_BITS-1:0]        in_re,
  input  logic [LIMB_BITS-1:0]        in_im,
  input  logic [TAG_BITS-1:0]         in_tag,
  input  logic                        in_last,
  output logic [NUM_SOLVERS-1:0]      sol_wr_en,
  output logic [LIMB_INDEX_BITS-1:0]  sol_wr_ind,
  output logic [LIMB_BITS-1:0]        sol_re,
  output logic [LIMB_BITS-1:0]        sol_im,
  output logic [NUM_SOLVERS-1:0]      sol_cfg_en,
  output logic [LIMB_INDEX_BITS-1:0]  sol_num_limbs,
  output logic [15:0]                 sol_iter_lim,
  output logic [NUM_SOLVERS-1:0]      sol_start,
  input  logic [NUM_SOLVERS-1:0]      sol_out_ready,
  input  logic [16*NUM_SOLVERS-1:0]   sol_iter_count,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [TAG_BITS-1:0]         res_tag,
  output logic [15:0]                 res_count,
  output logic [NUM_SOLVERS-1:0]      busy,
  output logic                        framing_err
);

  localparam int PW = $clog2(NUM_SOLVERS);

  typedef enum logic [1:0] {IDLE, LOAD, START} state_t;

  state_t                      state, state_next;
  logic [PW-1:0]               sel, dptr, cptr;
  logic [LIMB_INDEX_BITS-1:0]  k;
  logic [LIMB_INDEX_BITS-1:0]  num_limbs_q;
  logic [15:0]                 iter_lim_q;
  logic [TAG_BITS-1:0]         tag_mem [NUM_SOLVERS];
  logic [NUM_SOLVERS-1:0]      pend, busy_clr;
  logic                        free_found, pend_found, collect_slot, last_beat;
  logic [PW-1:0]               free_idx, pend_idx;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int j);
    int s;
    s = int'(p) + j;
    if (s >= NUM_SOLVERS) s = s - NUM_SOLVERS;
    return PW'(s);
  endfunction

  // A solver is collectable only once it has been started and reports done.
  assign pend          = busy & sol_out_ready;
  assign sol_re        = in_re;
  assign sol_im        = in_im;
  assign sol_num_limbs = num_limbs_q;
  assign sol_iter_lim  = iter_lim_q;
  assign sol_wr_ind    = (state == LOAD) ? k : '0;
  assign last_beat     = (k == num_limbs_q);
  assign collect_slot  = !res_valid || res_ready;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    pend_found = 1'b0;
    pend_idx   = '0;
    for (int j = 0; j < NUM_SOLVERS; j++) begin
      if (!free_found && !busy[wrap_add(dptr, j)]) begin
        free_found = 1'b1;
        free_idx   = wrap_add(dptr, j);
      end
      if (!pend_found && pend[wrap_add(cptr, j)]) begin
        pend_found = 1'b1;
        pend_idx   = wrap_add(cptr, j);
      end
    end
  end

  always_comb begin
    busy_clr = '0;
    if (collect_slot && pend_found) busy_clr[pend_idx] = 1'b1;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    sol_wr_en  = '0;
    sol_cfg_en = '0;
    sol_start  = '0;
    case (state)
      IDLE: begin
        if (in_valid && free_found) state_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sol_wr_en[sel] = 1'b1;
          if (k == '0) sol_cfg_en[sel] = 1'b1;
          if (last_beat) state_next = START;
        end
      end
      START: begin
        sol_start[sel] = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= '0;
      dptr        <= '0;
      cptr        <= '0;
      k           <= '0;
      num_limbs_q <= '0;
      iter_lim_q  <= '0;
      busy        <= '0;
      framing_err <= 1'b0;
      res_valid   <= 1'b0;
      res_tag     <= '0;
      res_count   <= '0;
      for (int i = 0; i < NUM_SOLVERS; i++) tag_mem[i] <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (cfg_wr) begin
            num_limbs_q <= cfg_num_limbs;
            iter_lim_q  <= cfg_iter_lim;
          end
          if (in_valid && free_found) sel <= free_idx;
          k <= '0;
        end
        LOAD: begin
          if (in_valid) begin
            k <= k + LIMB_INDEX_BITS'(1);
            if (k == '0) tag_mem[sel] <= in_tag;
            // Beat count decides the job length; in_last is only audited.
            if (in_last != last_beat) framing_err <= 1'b1;
          end
        end
        START: dptr <= wrap_add(sel, 1);
        default: ;
      endcase
      busy <= (busy & ~busy_clr) | sol_start;
      if (collect_slot) begin
        res_valid <= pend_found;
        if (pend_found) begin
          res_tag   <= tag_mem[pend_idx];
          res_count <= sol_iter_count[int'(pend_idx)*16 +: 16];
          cptr      <= wrap_add(pend_idx, 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_solver_dispatcher.sv
// tb/tb_solver_dispatcher.sv - self-checking bench for solver_dispatcher
// Directed scenarios plus a randomized run against a job/solver scoreboard.
module tb_solver_dispatcher;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_wr;
  logic [5:0]  cfg_num_limbs;
  logic [15:0] cfg_iter_lim;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_re, in_im;
  logic [15:0] in_tag;
  logic        in_last;
  logic [3:0]  sol_wr_en;
  logic [5:0]  sol_wr_ind;
  logic [31:0] sol_re, sol_im;
  logic [3:0]  sol_cfg_en;
  logic [5:0]  sol_num_limbs;
  logic [15:0] sol_iter_lim;
  logic [3:0]  sol_start;
  logic [3:0]  sol_out_ready;
  logic [63:0] sol_iter_count;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_tag;
  logic [15:0] res_count;
  logic [3:0]  busy;
  logic        framing_err;

  int total = 0;
  int bad   = 0;

  logic [3:0]  obs_wr_en  [8];
  logic [5:0]  obs_wr_ind [8];
  logic [3:0]  obs_cfg_en [8];
  logic [31:0] obs_re     [8];
  logic [3:0]  obs_start;
  int          start_wait;
  bit          job_ok;

  bit          auto_mode;
  bit          owned [4];
  int          timer [4];
  int          solver_tag [4];
  logic [15:0] exp_count [int];

  solver_dispatcher dut (
    .clock(clock), .reset(reset), .cfg_wr(cfg_wr), .cfg_num_limbs(cfg_num_limbs),
    .cfg_iter_lim(cfg_iter_lim), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_tag(in_tag), .in_last(in_last),
    .sol_wr_en(sol_wr_en), .sol_wr_ind(sol_wr_ind), .sol_re(sol_re), .sol_im(sol_im),
    .sol_cfg_en(sol_cfg_en), .sol_num_limbs(sol_num_limbs), .sol_iter_lim(sol_iter_lim),
    .sol_start(sol_start), .sol_out_ready(sol_out_ready), .sol_iter_count(sol_iter_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_count(res_count),
    .busy(busy), .framing_err(framing_err)
  );

  always #5 clock = ~clock;

  // Advance to the next falling edge; the solver model finishes jobs there.
  task automatic step();
    @(negedge clock);
    if (auto_mode) begin
      for (int i = 0; i < 4; i++) begin
        if (owned[i] && timer[i] > 0) begin
          timer[i]--;
          if (timer[i] == 0) begin
            sol_out_ready[i] = 1'b1;
            sol_iter_count[16*i +: 16] = exp_count[solver_tag[i]];
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 0; in_last = 0; in_re = 0; in_im = 0; in_tag = 0;
    cfg_wr = 0; cfg_num_limbs = 0; cfg_iter_lim = 0; sol_out_ready = 0;
    sol_iter_count = 0; res_ready = 0; auto_mode = 0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic set_cfg(input int nl, input logic [15:0] il);
    cfg_wr = 1'b1; cfg_num_limbs = 6'(nl); cfg_iter_lim = il;
    step();
    cfg_wr = 1'b0;
  endtask

  // Drives one job and records what the dispatcher did; leaves the bench in the start cycle.
  task automatic send_job(input logic [15:0] tag, input int nb, input int last_at);
    int b, guard;
    b = 0; guard = 0; job_ok = 1; obs_start = 0; start_wait = -1;
    in_valid = 1'b1; in_tag = tag;
    while (b < nb && guard < 100) begin
      in_re = {tag, 16'(b)}; in_im = ~in_re; in_last = (b == last_at);
      #1;
      if (in_ready) begin
        obs_wr_en[b] = sol_wr_en; obs_wr_ind[b] = sol_wr_ind;
        obs_cfg_en[b] = sol_cfg_en; obs_re[b] = sol_re;
        b++;
      end
      step(); guard++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (b < nb) job_ok = 0;
    for (int w = 0; w < 5 && obs_start == 0; w++) begin
      #1;
      if (sol_start != 0) begin obs_start = sol_start; start_wait = w; end
      else step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    total++; if (busy !== 4'b0) begin bad++; $display("FAIL reset_busy: got %b want 0000", busy); end
    total++; if ({sol_num_limbs, sol_iter_lim} !== 22'd0) begin bad++; $display("FAIL reset_shadow: got %h/%h want 0/0", sol_num_limbs, sol_iter_lim); end
    total++; if ({sol_wr_en, sol_cfg_en, sol_start, framing_err} !== 13'd0) begin bad++; $display("FAIL reset_strobes: got %b want 0", {sol_wr_en, sol_cfg_en, sol_start, framing_err}); end
    total++; if ({res_tag, res_count} !== 32'd0) begin bad++; $display("FAIL reset_res: got %h want 0", {res_tag, res_count}); end
  endtask

  task automatic test_single_job();
    do_reset();
    set_cfg(2, 16'd50);
    #1;
    total++; if (sol_num_limbs !== 6'd2 || sol_iter_lim !== 16'd50) begin bad++; $display("FAIL single_cfg: got %0d/%0d want 2/50", sol_num_limbs, sol_iter_lim); end
    send_job(16'h0011, 3, 2);
    total++; if (!job_ok) begin bad++; $display("FAIL single_beats: got timeout want 3 beats"); end
    for (int b = 0; b < 3; b++) begin
      total++; if (obs_wr_en[b] !== 4'b0001 || obs_wr_ind[b] !== 6'(b)) begin bad++; $display("FAIL single_wr beat%0d: got en=%b ind=%0d want en=0001 ind=%0d", b, obs_wr_en[b], obs_wr_ind[b], b); end
      total++; if (obs_re[b] !== {16'h0011, 16'(b)}) begin bad++; $display("FAIL single_re beat%0d: got %h want %h", b, obs_re[b], {16'h0011, 16'(b)}); end
    end
    total++; if (obs_cfg_en[0] !== 4'b0001 || obs_cfg_en[1] !== 4'b0000) begin bad++; $display("FAIL single_cfg_en: got %b,%b want 0001,0000", obs_cfg_en[0], obs_cfg_en[1]); end
    total++; if (obs_start !== 4'b0001 || start_wait != 0) begin bad++; $display("FAIL single_start: got %b wait=%0d want 0001 wait=0", obs_start, start_wait); end
    step(); #1;
    total++; if (busy !== 4'b0001) begin bad++; $display("FAIL single_busy: got %b want 0001", busy); end
    sol_out_ready[0] = 1'b1; sol_iter_count[15:0] = 16'd17;
    step(); #1;
    total++; if (res_valid !== 1'b1 || res_tag !== 16'h0011 || res_count !== 16'd17) begin bad++; $display("FAIL single_result: got v=%b tag=%h cnt=%0d want v=1 tag=0011 cnt=17", res_valid, res_tag, res_count); end
    total++; if (busy !== 4'b0000) begin bad++; $display("FAIL single_busy_clr: got %b want 0000", busy); end
    res_ready = 1'b1; sol_out_ready[0] = 1'b0;
    step(); #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_res_drop: got %b want 0", res_valid); end
  endtask

  task automatic test_all_busy();
    bit seen_ready;
    do_reset();
    set_cfg(0, 16'd10);
    for (int j = 0; j < 4; j++) begin
      send_job(16'(16'h0020 + j), 1, 0);
      total++; if (obs_start !== 4'(1 << j)) begin bad++; $display("FAIL fill_start job%0d: got %b want %b", j, obs_start, 4'(1 << j)); end
    end
    seen_ready = 0;
    in_valid = 1'b1; in_tag = 16'h0024; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(); #1;
      seen_ready |= in_ready;
    end
    total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got 1 want 0"); end
    total++; if (busy !== 4'b1111) begin bad++; $display("FAIL full_busy: got %b want 1111", busy); end
    sol_out_ready[2] = 1'b1; sol_iter_count[47:32] = 16'h0055; res_ready = 1'b1;
    step(); #1;
    total++; if (res_valid !== 1'b1 || res_tag !== 16'h0022 || res_count !== 16'h0055) begin bad++; $display("FAIL free2_result: got v=%b tag=%h cnt=%h want v=1 tag=0022 cnt=0055", res_valid, res_tag, res_count); end
    total++; if (busy !== 4'b1011) begin bad++; $display("FAIL free2_busy: got %b want 1011", busy); end
    sol_out_ready[2] = 1'b0;
    send_job(16'h0024, 1, 0);
    total++; if (obs_start !== 4'b0100) begin bad++; $display("FAIL job5_solver: got %b want 0100", obs_start); end
  endtask

  task automatic test_hold();
    do_reset();
    set_cfg(0, 16'd10);
    for (int j = 0; j < 4; j++) send_job(16'(16'h0030 + j), 1, 0);
    step(); #1;
    res_ready = 1'b0;
    sol_out_ready[1] = 1'b1; sol_iter_count[31:16] = 16'h0101;
    sol_out_ready[3] = 1'b1; sol_iter_count[63:48] = 16'h0303;
    step(); #1;
    total++; if (res_valid !== 1'b1 || res_tag !== 16'h0031 || res_count !== 16'h0101) begin bad++; $display("FAIL hold_first: got v=%b tag=%h cnt=%h want v=1 tag=0031 cnt=0101", res_valid, res_tag, res_count); end
    for (int c = 0; c < 4; c++) begin
      step(); #1;
      total++; if (res_valid !== 1'b1 || res_tag !== 16'h0031 || res_count !== 16'h0101) begin bad++; $display("FAIL hold_stable c%0d: got v=%b tag=%h cnt=%h want v=1 tag=0031 cnt=0101", c, res_valid, res_tag, res_count); end
    end
    res_ready = 1'b1;
    step(); #1;
    total++; if (res_valid !== 1'b1 || res_tag !== 16'h0033 || res_count !== 16'h0303) begin bad++; $display("FAIL hold_second: got v=%b tag=%h cnt=%h want v=1 tag=0033 cnt=0303", res_valid, res_tag, res_count); end
    step(); #1;
    total++; if (res_valid !== 1'b0 || busy !== 4'b0101) begin bad++; $display("FAIL hold_drain: got v=%b busy=%b want v=0 busy=0101", res_valid, busy); end
  endtask

  task automatic test_framing();
    do_reset();
    set_cfg(2, 16'd50);
    #1;
    total++; if (framing_err !== 1'b0) begin bad++; $display("FAIL framing_pre: got %b want 0", framing_err); end
    send_job(16'h0040, 3, 1);
    total++; if (!job_ok || obs_wr_ind[2] !== 6'd2) begin bad++; $display("FAIL framing_beats: got ok=%0d ind2=%0d want ok=1 ind2=2", job_ok, obs_wr_ind[2]); end
    total++; if (obs_start !== 4'b0001) begin bad++; $display("FAIL framing_start: got %b want 0001", obs_start); end
    total++; if (framing_err !== 1'b1) begin bad++; $display("FAIL framing_err: got %b want 1", framing_err); end
  endtask

  task automatic test_reset_mid_load();
    bit seen_start;
    do_reset();
    set_cfg(2, 16'd50);
    in_valid = 1'b1; in_tag = 16'h0050; in_last = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0 || busy !== 4'b0000) begin bad++; $display("FAIL midreset_state: got rdy=%b busy=%b want 0/0000", in_ready, busy); end
    seen_start = (sol_start != 0);
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      seen_start |= (sol_start != 0);
    end
    total++; if (seen_start !== 1'b0) begin bad++; $display("FAIL midreset_start: got pulse want none"); end
  endtask

  task automatic test_cfg_in_load();
    do_reset();
    set_cfg(2, 16'd50);
    in_valid = 1'b1; in_tag = 16'h0060; in_last = 1'b0;
    step();
    cfg_wr = 1'b1; cfg_num_limbs = 6'd5; cfg_iter_lim = 16'd99;
    for (int b = 0; b < 3; b++) begin
      in_last = (b == 2); in_re = 32'(b);
      step();
    end
    #1;
    total++; if (sol_start !== 4'b0001) begin bad++; $display("FAIL cfgload_start: got %b want 0001", sol_start); end
    total++; if (sol_num_limbs !== 6'd2 || sol_iter_lim !== 16'd50) begin bad++; $display("FAIL cfgload_shadow: got %0d/%0d want 2/50", sol_num_limbs, sol_iter_lim); end
    cfg_wr = 1'b0; in_valid = 1'b0;
    step();
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
    #1;
    total++; if (sol_num_limbs !== 6'd5 || sol_iter_lim !== 16'd99) begin bad++; $display("FAIL cfgidle_shadow: got %0d/%0d want 5/99", sol_num_limbs, sol_iter_lim); end
  endtask

  task automatic test_random();
    int njobs, issued, beat, got, nb, cyc, pend_tag, fi;
    logic pv, pr;
    logic [15:0] ptag, pcount;
    njobs = 40; issued = 0; beat = 0; got = 0; cyc = 0; pend_tag = 0;
    do_reset();
    nb = $urandom_range(0, 3);
    set_cfg(nb, 16'($urandom));
    nb = nb + 1;
    exp_count.delete();
    for (int j = 0; j < njobs; j++) exp_count['h1000 + j] = 16'($urandom);
    for (int i = 0; i < 4; i++) begin owned[i] = 0; timer[i] = 0; end
    auto_mode = 1; pv = 0; pr = 0; ptag = 0; pcount = 0;
    while (got < njobs && cyc < 20000) begin
      res_ready = ($urandom_range(0, 3) != 0);
      if (issued < njobs && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_tag = 16'('h1000 + issued);
        in_re = {in_tag, 16'(beat)}; in_im = ~in_re; in_last = (beat == nb - 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (pv && !pr) begin
        total++; if (res_valid !== 1'b1 || res_tag !== ptag || res_count !== pcount) begin bad++; $display("FAIL rand_hold: got v=%b %h/%h want v=1 %h/%h", res_valid, res_tag, res_count, ptag, pcount); end
      end
      if (sol_start != 0) begin
        total++; if (!$onehot(sol_start)) begin bad++; $display("FAIL rand_start_onehot: got %b want one-hot", sol_start); end
        for (int i = 0; i < 4; i++) if (sol_start[i]) begin
          total++; if (owned[i]) begin bad++; $display("FAIL rand_start_busy: got start on owned solver %0d want free solver", i); end
          owned[i] = 1; solver_tag[i] = pend_tag; sol_out_ready[i] = 1'b0;
          timer[i] = $urandom_range(1, 25);
        end
      end
      if (in_valid && in_ready) begin
        total++; if (!$onehot(sol_wr_en) || sol_wr_ind !== 6'(beat) || sol_re !== in_re) begin bad++; $display("FAIL rand_beat: got en=%b ind=%0d re=%h want onehot ind=%0d re=%h", sol_wr_en, sol_wr_ind, sol_re, beat, in_re); end
        beat++;
        if (beat == nb) begin pend_tag = 'h1000 + issued; issued++; beat = 0; end
      end
      if (res_valid && res_ready) begin
        fi = -1;
        for (int i = 0; i < 4; i++) if (owned[i] && solver_tag[i] == int'(res_tag) && sol_out_ready[i]) fi = i;
        total++; if (fi < 0 || res_count !== exp_count[int'(res_tag)]) begin bad++; $display("FAIL rand_result: got tag=%h cnt=%h solver=%0d want finished tag with cnt=%h", res_tag, res_count, fi, exp_count.exists(int'(res_tag)) ? exp_count[int'(res_tag)] : 16'hxxxx); end
        if (fi >= 0) owned[fi] = 0;
        got++;
      end
      pv = res_valid; pr = res_ready; ptag = res_tag; pcount = res_count;
      step(); cyc++;
    end
    in_valid = 1'b0; res_ready = 1'b1;
    total++; if (got != njobs) begin bad++; $display("FAIL rand_count: got %0d results want %0d", got, njobs); end
    step(); step(); #1;
    total++; if (busy !== 4'b0000 || framing_err !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL rand_idle: got busy=%b ferr=%b v=%b want 0000/0/0", busy, framing_err, res_valid); end
    auto_mode = 0;
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_all_busy();
    test_hold();
    test_framing();
    test_reset_mid_load();
    test_cfg_in_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
